// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave core.
//   spi_state_e : frame FSM states (idle / shifting)
//   spi_mode_t  : CPOL/CPHA pair; MODE0..MODE3 are the standard SPI modes
package spi_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
  localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
  localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
  localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous input bit.
//   clk, rst_n : destination clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronised output (last stage)
// RESET_VAL sets the value every stage takes during reset.
module spi_sync #(
  parameter int unsigned STAGES    = 2,
  parameter bit          RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave core, oversampled in the clk domain.
//   clk, rst_n       : peripheral clock, async active-low reset
//   sclk, cs_n, mosi : SPI bus from master (asynchronous)
//   miso             : registered serial data to master
//   rx_valid/rx_data : one-clk pulse and held word on each complete receive
//   tx_data/tx_taken : word to send, one-clk pulse each time it is loaded
//   busy             : frame in progress
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter bit          LSB_FIRST   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_taken,
  output logic              busy
);

  localparam int unsigned       CNT_W      = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(DATA_W - 1);
  // Edge detection is held off until the synchronisers and delay flops carry
  // real input values, so a cs_n already low at reset release is not a frame start.
  localparam logic [2:0]        FLUSH_DONE = 3'(SYNC_STAGES + 1);

  logic sclk_s, cs_n_s, mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_n_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s)
  );

  spi_state_e        state_q, state_d;
  logic              sclk_dly_q, sclk_dly_d, cs_dly_q, cs_dly_d;
  logic [2:0]        flush_q, flush_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              skip_q, skip_d;      // CPHA=1: first shift edge of frame is a no-op
  logic              reload_q, reload_d;  // word done: next shift edge loads tx_data
  logic              rx_valid_q, rx_valid_d, tx_taken_q, tx_taken_d, miso_q, miso_d;

  logic              sync_ready, lead, trail, sample_edge, shift_edge, cs_fall, cs_rise;
  logic [DATA_W-1:0] rx_next, tx_next;

  always_comb begin
    sync_ready  = (flush_q == FLUSH_DONE);
    flush_d     = sync_ready ? flush_q : flush_q + 3'd1;
    sclk_dly_d  = sclk_s;
    cs_dly_d    = cs_n_s;
    lead        = sync_ready && (sclk_dly_q == CPOL) && (sclk_s != CPOL);
    trail       = sync_ready && (sclk_dly_q != CPOL) && (sclk_s == CPOL);
    sample_edge = CPHA ? trail : lead;
    shift_edge  = CPHA ? lead : trail;
    cs_fall     = sync_ready && cs_dly_q && !cs_n_s;
    cs_rise     = sync_ready && !cs_dly_q && cs_n_s;
    rx_next     = LSB_FIRST ? {mosi_s, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], mosi_s};
    tx_next     = LSB_FIRST ? (tx_sr_q >> 1) : (tx_sr_q << 1);
  end

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    skip_d     = skip_q;
    reload_d   = reload_q;
    rx_valid_d = 1'b0;
    tx_taken_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d    = StShift;
          tx_sr_d    = tx_data;
          tx_taken_d = 1'b1;
          rx_sr_d    = '0;
          bit_cnt_d  = '0;
          skip_d     = CPHA;
          reload_d   = 1'b0;
        end
      end
      StShift: begin
        if (sample_edge) begin
          rx_sr_d = rx_next;
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            reload_d   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        if (shift_edge) begin
          if (skip_q) begin
            skip_d = 1'b0;
          end else if (reload_q) begin
            tx_sr_d    = tx_data;
            tx_taken_d = 1'b1;
            reload_d   = 1'b0;
          end else begin
            tx_sr_d = tx_next;
          end
        end
        // Evaluated after the sample edge so a word finishing in this clk still completes.
        if (cs_rise) begin
          state_d   = StIdle;
          rx_sr_d   = '0;
          bit_cnt_d = '0;
          skip_d    = 1'b0;
          reload_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    miso_d = (state_d == StShift) ? (LSB_FIRST ? tx_sr_d[0] : tx_sr_d[DATA_W-1]) : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sclk_dly_q <= CPOL;
      cs_dly_q   <= 1'b1;
      flush_q    <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      skip_q     <= 1'b0;
      reload_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_taken_q <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sclk_dly_q <= sclk_dly_d;
      cs_dly_q   <= cs_dly_d;
      flush_q    <= flush_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      skip_q     <= skip_d;
      reload_q   <= reload_d;
      rx_valid_q <= rx_valid_d;
      tx_taken_q <= tx_taken_d;
      miso_q     <= miso_d;
    end
  end

  assign miso     = miso_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign tx_taken = tx_taken_q;
  assign busy     = (state_q == StShift);

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: four 8-bit MSB-first instances (modes 0..3, index = mode)
// plus one 16-bit LSB-first mode-3 instance at index 4. A behavioural master drives
// sclk at clk/4; received words go through a scoreboard checked on rx_valid.
`timescale 1ns/1ps
module tb_spi_slave_core;
  import spi_pkg::*;

  localparam int H = 20;  // sclk half period (clk period 10 ns)

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] sclk_v, cs_v, mosi_v, miso_v, rx_valid_v, tx_taken_v, busy_v;
  logic [7:0]  tx8 [4];
  logic [7:0]  rx8 [4];
  logic [15:0] tx16, rx16;

  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam bit [1:0] MB = 2'(m);
    spi_slave_core #(.DATA_W(8), .SYNC_STAGES(2), .CPOL(MB[1]), .CPHA(MB[0]),
                     .LSB_FIRST(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk_v[m]), .cs_n(cs_v[m]), .mosi(mosi_v[m]),
      .miso(miso_v[m]), .rx_valid(rx_valid_v[m]), .rx_data(rx8[m]), .tx_data(tx8[m]),
      .tx_taken(tx_taken_v[m]), .busy(busy_v[m])
    );
  end

  spi_slave_core #(.DATA_W(16), .SYNC_STAGES(2), .CPOL(1'b1), .CPHA(1'b1),
                   .LSB_FIRST(1'b1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_v[4]), .cs_n(cs_v[4]), .mosi(mosi_v[4]),
    .miso(miso_v[4]), .rx_valid(rx_valid_v[4]), .rx_data(rx16), .tx_data(tx16),
    .tx_taken(tx_taken_v[4]), .busy(busy_v[4])
  );

  int n_cmp = 0;
  int n_fail = 0;
  int rxv_cnt [5];
  int txt_cnt [5];

  typedef struct {
    int          idx;
    logic [31:0] data;
  } sb_t;
  sb_t sb [$];

  typedef struct {
    int         idx;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic spi_mode_t mode_of(input int idx);
    case (idx)
      0:       return MODE0;
      1:       return MODE1;
      2:       return MODE2;
      default: return MODE3;
    endcase
  endfunction

  // Scoreboard consumer and pulse counters
  initial begin
    for (int i = 0; i < 5; i++) begin
      rxv_cnt[i] = 0;
      txt_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        if (tx_taken_v[i] === 1'b1) txt_cnt[i]++;
        if (rx_valid_v[i] === 1'b1) begin
          rxv_cnt[i]++;
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_empty: inst %0d pulsed rx_valid, got 1, expected no pulse", i);
          end else begin
            sb_t e;
            logic [31:0] act;
            e   = sb.pop_front();
            act = (i == 4) ? {16'h0, rx16} : {24'h0, rx8[i]};
            check("sb_inst", i, e.idx);
            check("sb_rx_data", act, e.data);
          end
        end
      end
    end
  end

  task automatic cs_low(input int idx, input real ph);
    @(posedge clk);
    #(ph);
    cs_v[idx] = 1'b0;
    #(2 * H);
  endtask

  task automatic cs_high(input int idx);
    #(H);
    cs_v[idx] = 1'b1;
    #(2 * H);
  endtask

  // Master: miso is sampled just before the next shift edge to absorb sync latency.
  task automatic m_xfer(input int idx, input int w, input bit lsb, input int nbits,
                        input logic [31:0] dout, input bit cs_at_end,
                        output logic [31:0] din);
    spi_mode_t md;
    int b;
    md  = mode_of(idx);
    din = '0;
    for (int i = 0; i < nbits; i++) begin
      b = lsb ? i : w - 1 - i;
      if (!md.cpha) begin
        mosi_v[idx] = dout[b];
        #(H);
        sclk_v[idx] = ~md.cpol;
        if (cs_at_end && i == nbits - 1) cs_v[idx] = 1'b1;
        #(H - 1);
        din[b] = miso_v[idx];
        #1;
        sclk_v[idx] = md.cpol;
      end else begin
        sclk_v[idx] = ~md.cpol;
        mosi_v[idx] = dout[b];
        #(H);
        sclk_v[idx] = md.cpol;
        if (cs_at_end && i == nbits - 1) cs_v[idx] = 1'b1;
        #(H - 1);
        din[b] = miso_v[idx];
        #1;
      end
    end
  endtask

  initial begin
    vec_t vecs [6];
    logic [31:0] din;
    int r0, t0;

    vecs[0] = '{idx: 0, tx: 8'hA5, mosi: 8'h3C, exp_rx: 8'h3C, exp_miso: 8'hA5};
    vecs[1] = '{idx: 1, tx: 8'h5A, mosi: 8'hC3, exp_rx: 8'hC3, exp_miso: 8'h5A};
    vecs[2] = '{idx: 2, tx: 8'hFF, mosi: 8'h00, exp_rx: 8'h00, exp_miso: 8'hFF};
    vecs[3] = '{idx: 3, tx: 8'h00, mosi: 8'hFF, exp_rx: 8'hFF, exp_miso: 8'h00};
    vecs[4] = '{idx: 0, tx: 8'h80, mosi: 8'h01, exp_rx: 8'h01, exp_miso: 8'h80};
    vecs[5] = '{idx: 3, tx: 8'h96, mosi: 8'h69, exp_rx: 8'h69, exp_miso: 8'h96};

    cs_v   = 5'b11111;
    mosi_v = 5'b00000;
    sclk_v = 5'b11100;  // idle at CPOL per instance
    for (int i = 0; i < 4; i++) tx8[i] = 8'h00;
    tx16  = 16'h0000;
    rst_n = 1'b0;
    #37;
    check("rst_miso", {27'h0, miso_v}, 32'h0);
    check("rst_rx_valid", {27'h0, rx_valid_v}, 32'h0);
    check("rst_tx_taken", {27'h0, tx_taken_v}, 32'h0);
    check("rst_busy", {27'h0, busy_v}, 32'h0);
    check("rst_rx_data8", {24'h0, rx8[0]}, 32'h0);
    check("rst_rx_data16", {16'h0, rx16}, 32'h0);
    rst_n = 1'b1;
    #50;

    // Single-word frames across modes
    for (int v = 0; v < 6; v++) begin
      r0 = rxv_cnt[vecs[v].idx];
      tx8[vecs[v].idx] = vecs[v].tx;
      cs_low(vecs[v].idx, 2.5);
      check("vec_busy", {31'h0, busy_v[vecs[v].idx]}, 32'h1);
      sb.push_back('{idx: vecs[v].idx, data: {24'h0, vecs[v].exp_rx}});
      m_xfer(vecs[v].idx, 8, 1'b0, 8, {24'h0, vecs[v].mosi}, 1'b0, din);
      cs_high(vecs[v].idx);
      check("vec_miso_word", din, {24'h0, vecs[v].exp_miso});
      check("vec_rx_data", {24'h0, rx8[vecs[v].idx]}, {24'h0, vecs[v].exp_rx});
      check("vec_rx_pulses", rxv_cnt[vecs[v].idx] - r0, 1);
      check("vec_idle_miso", {31'h0, miso_v[vecs[v].idx]}, 32'h0);
    end

    // Mode 3, 16-bit, LSB first
    tx16 = 16'h1234;
    cs_low(4, 3.5);
    sb.push_back('{idx: 4, data: 32'hBEEF});
    m_xfer(4, 16, 1'b1, 16, 32'hBEEF, 1'b0, din);
    cs_high(4);
    check("w16_miso_word", din, 32'h1234);
    check("w16_rx_data", {16'h0, rx16}, 32'hBEEF);

    // Mode 1, back-to-back words
    r0 = rxv_cnt[1];
    t0 = txt_cnt[1];
    tx8[1] = 8'h11;
    cs_low(1, 6.5);
    check("b2b_first_taken", txt_cnt[1] - t0, 1);
    tx8[1] = 8'h22;
    sb.push_back('{idx: 1, data: 32'hA1});
    m_xfer(1, 8, 1'b0, 8, 32'hA1, 1'b0, din);
    check("b2b_miso_w0", din, 32'h11);
    sb.push_back('{idx: 1, data: 32'h5B});
    m_xfer(1, 8, 1'b0, 8, 32'h5B, 1'b0, din);
    check("b2b_miso_w1", din, 32'h22);
    cs_high(1);
    check("b2b_rx_pulses", rxv_cnt[1] - r0, 2);
    check("b2b_tx_taken", txt_cnt[1] - t0, 2);

    // Mode 0, cs_n raised after 5 bits
    r0 = rxv_cnt[0];
    tx8[0] = 8'h00;
    cs_low(0, 1.5);
    m_xfer(0, 8, 1'b0, 5, 32'hFF, 1'b0, din);
    cs_high(0);
    check("abort_rx_hold", {24'h0, rx8[0]}, 32'h01);
    check("abort_no_pulse", rxv_cnt[0] - r0, 0);
    check("abort_busy", {31'h0, busy_v[0]}, 32'h0);
    cs_low(0, 4.5);
    sb.push_back('{idx: 0, data: 32'h7E});
    m_xfer(0, 8, 1'b0, 8, 32'h7E, 1'b0, din);
    cs_high(0);
    check("abort_next_rx", {24'h0, rx8[0]}, 32'h7E);

    // Mode 2, reset mid-frame, then idle sclk with cs_n still low
    tx8[2] = 8'h5A;
    cs_low(2, 7.5);
    m_xfer(2, 8, 1'b0, 4, 32'hC3, 1'b0, din);
    check("rstmid_busy_before", {31'h0, busy_v[2]}, 32'h1);
    rst_n = 1'b0;
    #12;
    check("rstmid_miso", {27'h0, miso_v}, 32'h0);
    check("rstmid_busy", {27'h0, busy_v}, 32'h0);
    check("rstmid_rx_valid", {27'h0, rx_valid_v}, 32'h0);
    check("rstmid_tx_taken", {27'h0, tx_taken_v}, 32'h0);
    check("rstmid_rx_data", {24'h0, rx8[2]}, 32'h0);
    rst_n = 1'b1;
    r0 = rxv_cnt[2];
    #100;
    for (int k = 0; k < 8; k++) begin
      sclk_v[2] = ~sclk_v[2];
      #(H);
    end
    check("rstmid_no_restart", {31'h0, busy_v[2]}, 32'h0);
    check("rstmid_no_pulse", rxv_cnt[2] - r0, 0);
    cs_high(2);
    tx8[2] = 8'h3C;
    cs_low(2, 5.5);
    sb.push_back('{idx: 2, data: 32'hC3});
    m_xfer(2, 8, 1'b0, 8, 32'hC3, 1'b0, din);
    cs_high(2);
    check("rstmid_next_rx", {24'h0, rx8[2]}, 32'hC3);
    check("rstmid_next_miso", din, 32'h3C);

    // Mode 3, cs_n rises together with the final sample edge
    r0 = rxv_cnt[3];
    tx8[3] = 8'h0F;
    cs_low(3, 8.5);
    sb.push_back('{idx: 3, data: 32'hD2});
    m_xfer(3, 8, 1'b0, 8, 32'hD2, 1'b1, din);
    #(3 * H);
    check("csend_rx_data", {24'h0, rx8[3]}, 32'hD2);
    check("csend_pulse", rxv_cnt[3] - r0, 1);

    // Random words, random mode and sclk-to-clk phase
    for (int n = 0; n < 1000; n++) begin
      int idx;
      logic [7:0] tx, mo;
      real ph;
      idx = int'($urandom_range(0, 3));
      tx  = 8'($urandom);
      mo  = 8'($urandom);
      ph  = real'($urandom_range(0, 9)) + 0.5;
      tx8[idx] = tx;
      cs_low(idx, ph);
      sb.push_back('{idx: idx, data: {24'h0, mo}});
      m_xfer(idx, 8, 1'b0, 8, {24'h0, mo}, 1'b0, din);
      cs_high(idx);
      check("rand_miso_word", din, {24'h0, tx});
    end

    #100;
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
